// File: rtl/mem_arbiter_pkg.sv
// Shared types for the LC-3b physical-memory arbiter (line type, FSM state, owner encoding).
package mem_arbiter_pkg;

    typedef logic [127:0] lc3b_line;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2,
        DONE    = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } arb_owner_t;

endpackage

// File: rtl/arb_pick.sv
// Combinational winner select between I-cache and D-cache requests.
// ARB_ROUND_ROBIN_EN: on a tie, grant the requester not served last; otherwise D always wins.
module arb_pick
    import mem_arbiter_pkg::*;
(
    input  logic       i_req,
    input  logic       d_req,
    input  arb_owner_t last_served,
    output arb_owner_t owner,
    output logic       valid
);

`ifdef ARB_ROUND_ROBIN_EN
    logic tie;
    assign tie = i_req && d_req;
`else
    logic unused_last_served;
    assign unused_last_served = (last_served == OWN_D);
`endif

    always_comb begin
        valid = i_req || d_req;
        owner = d_req ? OWN_D : OWN_I;
`ifdef ARB_ROUND_ROBIN_EN
        if (tie)
            owner = (last_served == OWN_I) ? OWN_D : OWN_I;
`endif
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one physical-memory port between I-cache and D-cache; grants, snapshots the request,
// and steers pmem_resp back to the owner. Tie-break policy selected by ARB_ROUND_ROBIN_EN.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int LINE_W = 128
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_address,
    output logic              i_resp,
    output logic [LINE_W-1:0] i_rdata,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [LINE_W-1:0] d_wdata,
    output logic              d_resp,
    output logic [LINE_W-1:0] d_rdata,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp,
    output logic              busy
);

    arb_state_t        state;
    arb_owner_t        last_served;
    arb_owner_t        pick_owner;
    logic              pick_valid;
    logic              d_req;
    logic [ADDR_W-1:0] snap_address;
    logic [LINE_W-1:0] snap_wdata;
    logic              snap_write;

    assign d_req = d_read || d_write;

    arb_pick u_pick (
        .i_req       (i_read),
        .d_req       (d_req),
        .last_served (last_served),
        .owner       (pick_owner),
        .valid       (pick_valid)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            last_served  <= OWN_I;
            snap_address <= '0;
            snap_wdata   <= '0;
            snap_write   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        last_served <= pick_owner;
                        if (pick_owner == OWN_D) begin
                            state        <= SERVE_D;
                            snap_address <= d_address;
                            snap_wdata   <= d_wdata;
                            // read+write together is illegal; the write takes precedence
                            snap_write   <= d_write;
                        end else begin
                            state        <= SERVE_I;
                            snap_address <= i_address;
                            snap_write   <= 1'b0;
                        end
                    end
                end
                SERVE_I, SERVE_D: begin
                    if (pmem_resp)
                        state <= DONE;
                end
                // one dead cycle lets the served cache drop its request before re-arbitration
                default: state <= IDLE;
            endcase
        end
    end

    assign busy         = (state == SERVE_I) || (state == SERVE_D);
    assign pmem_read    = busy && !snap_write;
    assign pmem_write   = busy && snap_write;
    assign pmem_address = snap_address;
    assign pmem_wdata   = snap_wdata;

    assign i_resp  = (state == SERVE_I) && pmem_resp;
    assign d_resp  = (state == SERVE_D) && pmem_resp;
    assign i_rdata = pmem_rdata;
    assign d_rdata = pmem_rdata;

endmodule
